usrp_tag_prmb_gen: RTL and testbench

- Upstream stage of the tag-chip MTX controller. Generates the BPSK location-sync preamble on the fly from an LFSR, replacing the preamble-bit ROM image.
- Emits oversampled ±AMPL I/Q samples on an AXI-stream-style handshake.
- Frames each preamble with start/done so the controller can sequence INIT → LOC_SYNC → LOC_IDLE.

---
 rtl/usrp_tag_prmb_gen_pkg.sv | 26 ++
 rtl/usrp_tag_prmb_gen_lfsr.sv | 44 ++++
 rtl/usrp_tag_prmb_gen.sv | 150 +++++++++++++++
 tb/tb_usrp_tag_prmb_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/usrp_tag_prmb_gen_pkg.sv
// Shared types, defaults and counter-width helpers for the tag-chip preamble
// generator and the MTX controller that sequences it.
package usrp_tag_prmb_gen_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } prmb_state_e;

  localparam int unsigned     DEF_DATA_WIDTH = 32'd16;
  localparam int unsigned     DEF_AMPL       = 32'd16384;
  localparam int unsigned     DEF_LFSR_WIDTH = 32'd11;
  localparam logic [10:0]     DEF_LFSR_TAPS  = 11'h005;
  localparam logic [10:0]     DEF_LFSR_SEED  = 11'h001;
  localparam int unsigned     DEF_NPRMB_BITS = 32'd2046;
  localparam int unsigned     DEF_PRMB_OS    = 32'd256;

  // Width of a counter that must be able to hold 0..max_count inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 32'd1) ? 32'd1 : $clog2(max_count + 32'd1);
  endfunction

  localparam int unsigned PRMB_BIT_IDX_W = cnt_width(DEF_NPRMB_BITS);
  localparam int unsigned PRMB_OS_IDX_W  = cnt_width(DEF_PRMB_OS);

endpackage

// File: rtl/usrp_tag_prmb_gen_lfsr.sv
// Right-shift Fibonacci LFSR, kept free of framing logic so the receive-side
// correlator reference can reuse it unchanged.
module usrp_tag_lfsr
  import usrp_tag_prmb_gen_pkg::*;
#(
  parameter int unsigned       WIDTH     = DEF_LFSR_WIDTH,
  parameter logic [WIDTH-1:0]  TAPS      = DEF_LFSR_TAPS,
  parameter logic [WIDTH-1:0]  RESET_VAL = DEF_LFSR_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  // Next state: load wins over step; feedback enters at the MSB.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (step) begin
      state_d = {^(state_q & TAPS), state_q[WIDTH-1:1]};
    end else begin
      state_d = state_q;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/usrp_tag_prmb_gen.sv
// BPSK location-sync preamble generator: LFSR bits oversampled into +/-AMPL
// I/Q samples on a valid/ready stream, framed by busy and a done pulse.
module usrp_tag_prmb_gen
  import usrp_tag_prmb_gen_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned            NPRMB_BITS = DEF_NPRMB_BITS,
  parameter int unsigned            PRMB_OS    = DEF_PRMB_OS,
  parameter int unsigned            LFSR_WIDTH = DEF_LFSR_WIDTH,
  parameter logic [LFSR_WIDTH-1:0]  LFSR_TAPS  = DEF_LFSR_TAPS,
  parameter logic [LFSR_WIDTH-1:0]  LFSR_SEED  = DEF_LFSR_SEED,
  parameter int unsigned            AMPL       = DEF_AMPL
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                abort,
  output logic [2*DATA_WIDTH-1:0]             o_tdata,
  output logic                                o_tvalid,
  input  logic                                o_tready,
  output logic                                bit_out,
  output logic                                busy,
  output logic                                done,
  output logic [cnt_width(NPRMB_BITS)-1:0]    bit_idx,
  output logic [cnt_width(PRMB_OS)-1:0]       os_idx
);

  localparam int unsigned BW = cnt_width(NPRMB_BITS);
  localparam int unsigned OW = cnt_width(PRMB_OS);

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [LFSR_WIDTH-1:0] SEED_EFF =
    (LFSR_SEED == {LFSR_WIDTH{1'b0}}) ? LFSR_WIDTH'(32'd1) : LFSR_SEED;
  localparam logic [BW-1:0]         BIT_LAST = BW'(NPRMB_BITS - 32'd1);
  localparam logic [OW-1:0]         OS_LAST  = OW'(PRMB_OS - 32'd1);
  localparam logic [BW-1:0]         BIT_ONE  = BW'(32'd1);
  localparam logic [OW-1:0]         OS_ONE   = OW'(32'd1);
  localparam logic [DATA_WIDTH-1:0] AMPL_POS = DATA_WIDTH'(AMPL);
  localparam logic [DATA_WIDTH-1:0] AMPL_NEG = (~AMPL_POS) + DATA_WIDTH'(32'd1);

  prmb_state_e           state_q, state_d;
  logic [BW-1:0]         bit_idx_q, bit_idx_d;
  logic [OW-1:0]         os_idx_q, os_idx_d;
  logic                  done_q, done_d;
  logic                  lfsr_load_s, lfsr_step_s, lfsr_stuck_s, run_s;
  logic [LFSR_WIDTH-1:0] lfsr_state_s;

  usrp_tag_lfsr #(
    .WIDTH     (LFSR_WIDTH),
    .TAPS      (LFSR_TAPS),
    .RESET_VAL (SEED_EFF)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load_s),
    .seed  (SEED_EFF),
    .step  (lfsr_step_s),
    .state (lfsr_state_s)
  );

  assign run_s        = (state_q == ST_RUN);
  assign lfsr_stuck_s = (lfsr_state_s == {LFSR_WIDTH{1'b0}});

  // Sequencing: abort dominates; counters and LFSR only advance on a transfer.
  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    os_idx_d    = os_idx_q;
    done_d      = 1'b0;
    lfsr_load_s = lfsr_stuck_s;
    lfsr_step_s = 1'b0;
    if (abort) begin
      state_d     = ST_IDLE;
      bit_idx_d   = {BW{1'b0}};
      os_idx_d    = {OW{1'b0}};
      lfsr_load_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d     = ST_RUN;
            bit_idx_d   = {BW{1'b0}};
            os_idx_d    = {OW{1'b0}};
            lfsr_load_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (o_tready && (os_idx_q == OS_LAST)) begin
            os_idx_d    = {OW{1'b0}};
            lfsr_step_s = 1'b1;
            if (bit_idx_q == BIT_LAST) begin
              state_d   = ST_IDLE;
              bit_idx_d = {BW{1'b0}};
              done_d    = 1'b1;
            end else begin
              bit_idx_d = bit_idx_q + BIT_ONE;
            end
          end else if (o_tready) begin
            os_idx_d = os_idx_q + OS_ONE;
          end else begin
            os_idx_d = os_idx_q;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          bit_idx_d   = {BW{1'b0}};
          os_idx_d    = {OW{1'b0}};
          lfsr_load_s = 1'b1;
        end
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= {BW{1'b0}};
      os_idx_q  <= {OW{1'b0}};
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      os_idx_q  <= os_idx_d;
      done_q    <= done_d;
    end
  end

  // Sample mapping straight from registered state, so no added latency.
  always_comb begin
    o_tdata = {(2*DATA_WIDTH){1'b0}};
    if (run_s && lfsr_state_s[0]) begin
      o_tdata = {AMPL_POS, AMPL_POS};
    end else if (run_s) begin
      o_tdata = {AMPL_NEG, AMPL_NEG};
    end else begin
      o_tdata = {(2*DATA_WIDTH){1'b0}};
    end
  end

  assign o_tvalid = run_s;
  assign busy     = run_s;
  assign bit_out  = run_s & lfsr_state_s[0];
  assign done     = done_q;
  assign bit_idx  = bit_idx_q;
  assign os_idx   = os_idx_q;

endmodule

// File: tb/tb_usrp_tag_prmb_gen.sv
// Randomized self-checking bench for usrp_tag_prmb_gen against a software
// LFSR/sample model; oversampling is reduced to keep full bursts short.
module tb_usrp_tag_prmb_gen;

  localparam int NB    = 2046;
  localparam int OS    = 8;
  localparam int TOTAL = NB * OS;
  localparam int BW    = $clog2(NB + 1);
  localparam int OW    = $clog2(OS + 1);

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          start    = 1'b0;
  logic          abort    = 1'b0;
  logic          o_tready = 1'b0;
  logic [31:0]   o_tdata;
  logic          o_tvalid;
  logic          bit_out;
  logic          busy;
  logic          done;
  logic [BW-1:0] bit_idx;
  logic [OW-1:0] os_idx;

  int n_checks = 0;
  int n_fail   = 0;
  bit ref_bits[NB];

  always #5 clk = ~clk;

  usrp_tag_prmb_gen #(
    .NPRMB_BITS (NB),
    .PRMB_OS    (OS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .o_tdata  (o_tdata),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .bit_out  (bit_out),
    .busy     (busy),
    .done     (done),
    .bit_idx  (bit_idx),
    .os_idx   (os_idx)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Polynomial x^11 + x^2 + 1, seed 1, output bit = LSB, new bit enters at bit 10.
  task automatic build_ref();
    int s = 1;
    int fb;
    for (int i = 0; i < NB; i++) begin
      ref_bits[i] = s[0];
      fb = (s ^ (s >> 2)) & 1;
      s  = (s >> 1) | (fb << 10);
    end
  endtask

  function automatic logic [31:0] exp_sample(input int k);
    return ref_bits[k / OS] ? 32'h4000_4000 : 32'hC000_C000;
  endfunction

  // stop_mode: 0 run to completion, 1 abort at transfer stop_k, 2 async reset at stop_k.
  task automatic run_burst(input int rdy_pct, input int poke_bit, input int stop_k,
                           input int stop_mode, input bit skip_start, input bit chain_out);
    int          k        = 0;
    int          cyc      = 0;
    int          last_cyc = -10;
    int          done_cyc = -1;
    int          n_done   = 0;
    logic [31:0] held     = 32'h0;
    bit          stalled  = 1'b0;
    bit          poked    = 1'b0;
    bit          fin      = 1'b0;
    if (!skip_start) begin
      start    = 1'b1;
      o_tready = 1'b1;
      @(negedge clk);
      check("pre_start_valid", 64'(o_tvalid), 64'd0);
      @(posedge clk); #1;
      start = 1'b0;
    end
    while (!fin) begin
      if (cyc >= 3 * TOTAL + 100) begin
        check("burst_timeout", 64'(k), 64'(TOTAL));
        fin = 1'b1;
      end else begin
        o_tready = (k < TOTAL) ? ($urandom_range(99) < rdy_pct) : 1'b1;
        start    = (poke_bit >= 0) && !poked && (k == poke_bit * OS);
        poked    = poked | start;
        start    = start | (chain_out && (cyc == last_cyc + 1));
        abort    = (stop_mode == 1) && (k == stop_k);
        if (abort) o_tready = 1'b0;
        @(negedge clk);
        if (done) begin
          n_done++;
          done_cyc = cyc;
        end
        if (k < TOTAL) begin
          check("tvalid", 64'(o_tvalid), 64'd1);
          check("busy", 64'(busy), 64'd1);
          check("bit_idx", 64'(bit_idx), 64'(k / OS));
          check("os_idx", 64'(os_idx), 64'(k % OS));
          check("bit_out", 64'(bit_out), 64'(ref_bits[k / OS]));
          if (stalled) check("stall_hold", 64'(o_tdata), 64'(held));
          if (o_tready) begin
            check("sample", 64'(o_tdata), 64'(exp_sample(k)));
            k++;
            stalled = 1'b0;
            if (k == TOTAL) last_cyc = cyc;
          end else begin
            held    = o_tdata;
            stalled = 1'b1;
          end
        end else begin
          check("end_valid", 64'(o_tvalid), 64'd0);
          check("end_tdata", 64'(o_tdata), 64'd0);
          fin = (cyc >= last_cyc + (chain_out ? 1 : 3));
        end
        if (abort) begin
          // Second abort arrives together with start while idle: must stay idle.
          @(posedge clk); #1;
          start = 1'b1;
          @(negedge clk);
          check("abort_valid", 64'(o_tvalid), 64'd0);
          check("abort_bit_idx", 64'(bit_idx), 64'd0);
          check("abort_os_idx", 64'(os_idx), 64'd0);
          check("abort_done", 64'(done), 64'd0);
          @(posedge clk); #1;
          abort = 1'b0;
          start = 1'b0;
          for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_idle_valid", 64'(o_tvalid), 64'd0);
            check("abort_no_done", 64'(done), 64'd0);
            @(posedge clk); #1;
          end
          fin = 1'b1;
        end else if (stop_mode == 2 && k == stop_k) begin
          #2;
          reset = 1'b1;
          #1;
          check("arst_tvalid", 64'(o_tvalid), 64'd0);
          check("arst_tdata", 64'(o_tdata), 64'd0);
          check("arst_busy", 64'(busy), 64'd0);
          check("arst_bit_idx", 64'(bit_idx), 64'd0);
          check("arst_os_idx", 64'(os_idx), 64'd0);
          @(posedge clk); #2;
          reset = 1'b0;
          for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("arst_idle_valid", 64'(o_tvalid), 64'd0);
            @(posedge clk); #1;
          end
          fin = 1'b1;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    if (stop_mode == 0) begin
      check("done_count", 64'(n_done), 64'd1);
      check("done_latency", 64'(done_cyc), 64'(last_cyc + 1));
    end
  endtask

  initial begin
    build_ref();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(o_tvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_tdata", 64'(o_tdata), 64'd0);
    check("rst_bit_idx", 64'(bit_idx), 64'd0);
    check("rst_os_idx", 64'(os_idx), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_no_start", 64'(o_tvalid), 64'd0);
    @(posedge clk); #1;

    // Full burst with ignored start at bit 5, chained back-to-back into a stalled burst.
    run_burst(100, 5, 0, 0, 1'b0, 1'b1);
    run_burst(50, -1, 0, 0, 1'b1, 1'b0);
    // Abort at bit 100 / sample 5, then replay from seed.
    run_burst(100, -1, 100 * OS + 5, 1, 1'b0, 1'b0);
    run_burst(70, -1, 3 * OS + 2, 1, 1'b0, 1'b0);
    // Asynchronous reset mid-burst, then replay from seed.
    run_burst(60, -1, 40 * OS + 3, 2, 1'b0, 1'b0);
    run_burst(100, -1, 2 * OS, 1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
